// File: rtl/datapath_pkg.sv
// Shared types and sizing for the 16-bit, 8-register pipelined datapath.
package datapath_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int PEND_W   = 2;
    localparam int RET_W    = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    // Writeback bundle produced by the EX stage and carried on the wb_* ports.
    typedef struct packed {
        logic      valid;
        logic      wr_en;
        reg_addr_t rd;
        word_t     data;
    } wb_bundle_t;

endpackage

// File: rtl/datapath_rf_write_rf_scoreboard.sv
// Per-register pending-write counters with sticky overflow/underflow flags.
module rf_scoreboard
    import datapath_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_rd,
    output logic [NUM_REGS-1:0] pend_nonzero,
    output logic [NUM_REGS-1:0] pend_gt1,
    output logic                sb_overflow,
    output logic                sb_underflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [NUM_REGS-1:0] ovf_hit;
    logic [NUM_REGS-1:0] unf_hit;
    logic                sb_overflow_q;
    logic                sb_overflow_d;
    logic                sb_underflow_q;
    logic                sb_underflow_d;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            logic              inc;
            logic              dec;
            logic              ovf;
            logic              unf;
            logic [PEND_W-1:0] pend_q;
            logic [PEND_W-1:0] pend_d;

            assign inc = issue_valid & issue_wr & (issue_rd == REG_AW'(gi));
            assign dec = wb_we & (wb_rd == REG_AW'(gi));

            // Saturating up/down counter; a same-cycle issue and writeback cancel without flagging.
            always_comb begin
                pend_d = pend_q;
                ovf    = 1'b0;
                unf    = 1'b0;
                if (inc && !dec) begin
                    if (pend_q == PEND_MAX) ovf = 1'b1;
                    else                    pend_d = pend_q + PEND_W'(1);
                end else if (dec && !inc) begin
                    if (pend_q == '0) unf = 1'b1;
                    else              pend_d = pend_q - PEND_W'(1);
                end
            end

            // Counter register.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) pend_q <= '0;
                else        pend_q <= pend_d;
            end

            assign ovf_hit[gi]      = ovf;
            assign unf_hit[gi]      = unf;
            assign pend_nonzero[gi] = (pend_q != '0);
            assign pend_gt1[gi]     = (pend_q > PEND_W'(1));
        end
    endgenerate

    // Flags only ever accumulate; reset is the sole way to clear them.
    always_comb begin
        sb_overflow_d  = sb_overflow_q  | (|ovf_hit);
        sb_underflow_d = sb_underflow_q | (|unf_hit);
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_overflow_q  <= 1'b0;
            sb_underflow_q <= 1'b0;
        end else begin
            sb_overflow_q  <= sb_overflow_d;
            sb_underflow_q <= sb_underflow_d;
        end
    end

    assign sb_overflow  = sb_overflow_q;
    assign sb_underflow = sb_underflow_q;

endmodule

// File: rtl/datapath_rf_write.sv
// Writeback end of the register file: 8x16 RF, bypassed read ports, busy scoreboard.
module datapath_rf_write
    import datapath_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wb_valid,
    input  logic                               wb_wr_en,
    input  logic [REG_AW-1:0]                  wb_rd,
    input  logic [DATA_W-1:0]                  wb_data,
    input  logic                               issue_valid,
    input  logic                               issue_wr,
    input  logic [REG_AW-1:0]                  issue_rd,
    input  logic [REG_AW-1:0]                  rx_addr,
    input  logic [REG_AW-1:0]                  ry_addr,
    output logic [DATA_W-1:0]                  rx_data,
    output logic [DATA_W-1:0]                  ry_data,
    output logic                               rx_busy,
    output logic                               ry_busy,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    RF,
    output logic [RET_W-1:0]                   retired,
    output logic                               sb_overflow,
    output logic                               sb_underflow
);

    wb_bundle_t          wb;
    logic                wb_we;
    logic                hit_x;
    logic                hit_y;
    logic [NUM_REGS-1:0] pend_nonzero;
    logic [NUM_REGS-1:0] pend_gt1;
    logic [RET_W-1:0]    retired_q;
    logic [RET_W-1:0]    retired_d;

    assign wb.valid = wb_valid;
    assign wb.wr_en = wb_wr_en;
    assign wb.rd    = wb_rd;
    assign wb.data  = wb_data;

    assign wb_we = wb.valid & wb.wr_en;
    assign hit_x = wb_we & (wb.rd == rx_addr);
    assign hit_y = wb_we & (wb.rd == ry_addr);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            word_t rf_q;
            word_t rf_d;

            // Commit the writeback value into the addressed entry.
            always_comb begin
                rf_d = rf_q;
                if (wb_we && (wb.rd == REG_AW'(gi))) rf_d = wb.data;
            end

            // Register-file entry.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) rf_q <= '0;
                else        rf_q <= rf_d;
            end

            assign RF[gi] = rf_q;
        end
    endgenerate

    // Count every accepted bundle, writing or not; wraps naturally.
    always_comb begin
        retired_d = retired_q;
        if (wb.valid) retired_d = retired_q + RET_W'(1);
    end

    // Retired-writeback counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired_q <= '0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;

    rf_scoreboard u_sb (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .wb_we        (wb_we),
        .wb_rd        (wb.rd),
        .pend_nonzero (pend_nonzero),
        .pend_gt1     (pend_gt1),
        .sb_overflow  (sb_overflow),
        .sb_underflow (sb_underflow)
    );

    // Read ports: same-cycle bypass wins; a bypass retires one outstanding write,
    // so busy needs two pending when bypassing. Outputs are forced quiet in reset
    // so a live bypass cannot leak through.
    always_comb begin
        rx_data = '0;
        ry_data = '0;
        rx_busy = 1'b0;
        ry_busy = 1'b0;
        if (reset) begin
            rx_data = hit_x ? wb.data : RF[rx_addr];
            ry_data = hit_y ? wb.data : RF[ry_addr];
            rx_busy = hit_x ? pend_gt1[rx_addr] : pend_nonzero[rx_addr];
            ry_busy = hit_y ? pend_gt1[ry_addr] : pend_nonzero[ry_addr];
        end
    end

endmodule

// File: doc/datapath_rf_write.md
Name: datapath_RF_Write

Overview:
Writeback end of the register-file interface for the 16-bit, 8-register pipelined datapath. It owns the 8x16 register file and commits results that arrive from the EX/MEM side. It serves two combinational read ports, with same-cycle write bypass, to the RF-read stage. A per-register pending-write scoreboard tells the RF-read stage when an operand is not yet valid.

Parameters:
NUM_REGS, 8, number of architectural registers (register address width is clog2(NUM_REGS) = 3)
DATA_W, 16, register width
PEND_W, 2, width of each pending-write counter (maximum 2^PEND_W - 1 writes in flight per register)
RET_W, 16, width of the retired-writeback counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
wb_valid  in  1  a writeback bundle is present this cycle
wb_wr_en  in  1  the bundle writes a register (ignored unless wb_valid)
wb_rd  in  3  destination register of the bundle
wb_data  in  16  value to commit
issue_valid  in  1  an instruction leaves RF-read this cycle
issue_wr  in  1  the issuing instruction will write a register
issue_rd  in  3  destination register of the issuing instruction
rx_addr  in  3  read port X address
ry_addr  in  3  read port Y address
rx_data  out  16  read port X data (combinational)
ry_data  out  16  read port Y data (combinational)
rx_busy  out  1  rx_data is stale: a write is still outstanding
ry_busy  out  1  ry_data is stale: a write is still outstanding
RF  out  8x16 packed  full register-file contents (debug and top-level visibility)
retired  out  16  count of accepted wb_valid bundles, including non-writing bundles
sb_overflow  out  1  sticky: an issue arrived when the destination counter was at its maximum
sb_underflow  out  1  sticky: a writeback arrived when the destination counter was 0

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-operation): all RF entries, all pending counters, retired, sb_overflow and sb_underflow are cleared to 0. While reset is asserted, rx_data and ry_data read 0, and rx_busy and ry_busy are 0.
- Commit: at a posedge with wb_valid & wb_wr_en, RF[wb_rd] <= wb_data. Visible on the RF output the next cycle.
- Bypass: if wb_valid & wb_wr_en & (wb_rd == rx_addr), then rx_data = wb_data in the same cycle. Otherwise rx_data = RF[rx_addr]. Port Y behaves identically. Zero-cycle latency.
- Scoreboard: one counter pend[r] per register.
  - inc = issue_valid & issue_wr & (issue_rd == r)
  - dec = wb_valid & wb_wr_en & (wb_rd == r)
  - inc & !dec: pend +1; if pend is at its maximum, hold and set sb_overflow.
  - dec & !inc: pend -1; if pend is 0, hold at 0 and set sb_underflow. The RF write still happens.
  - inc & dec on the same register in the same cycle: pend unchanged. No flag is set, even at 0 or max.
- Busy: rx_busy = (pend[rx_addr] > bypass_hit_x), where bypass_hit_x is 1 when the port X bypass is active, else 0. Rule: with pend == 1 and a same-cycle bypass, busy = 0; with pend >= 2, busy = 1 regardless of bypass. ry_busy is computed the same way.
- Issue and busy are independent: this block never stalls. The RF-read stage must withhold issue_valid while busy is high.
- retired: +1 at each posedge with wb_valid, regardless of wb_wr_en. Wraps from 0xFFFF to 0x0000.
- Sticky flags: once set, sb_overflow and sb_underflow are cleared only by reset.
- All addresses are full-range. R0 is an ordinary writable register, and R7 is writable (link register).

Decomposition:
- Shared package datapath_pkg: DATA_W, NUM_REGS, REG_AW, the typedefs reg_addr_t and word_t, and the packed struct wb_bundle_t {valid, wr_en, rd, data}. The EX stage drives the wb_* ports using this struct.
- One sub-module, rf_scoreboard, holds the pend counters, the inc/dec logic and the sticky flags. It exports pend_nonzero and pend_gt1 vectors for the busy computation. The RF array and the bypass muxes stay in the top module.

Test Plan:
- Reset: with reset=0 and the ports driven randomly → RF all 0, retired=0, flags 0; release reset, read R3 → rx_data=0x0000, rx_busy=0.
- Commit and bypass: wb writes R2=0xBEEF while rx_addr=2 → rx_data=0xBEEF in the same cycle; next cycle with wb_valid=0 → RF[2]=0xBEEF and rx_data=0xBEEF.
- Scoreboard: issue R5 twice (pend=2); ry_addr=5 → ry_busy=1. Writeback R5=0x0011 → ry_busy=1 during the write cycle, then pend=1. Writeback R5=0x0022 → ry_busy=0 with ry_data=0x0022 via bypass in that cycle; afterwards pend=0.
- Simultaneous events: issue R1 and writeback R1 in the same cycle while pend[1]=1 → pend[1] stays 1, RF[1] updated. Repeat at pend=0 → sb_underflow stays 0.
- Saturation and sticky flags: 4 issues to R4 with PEND_W=2 → pend=3 and sb_overflow=1. A writeback to R6 with pend=0 → sb_underflow=1 and RF[6] still written. Both flags persist until reset.
- Retired wrap: preload retired to 0xFFFF (via 65535 wb_valid cycles or a forced initial state) → one wb_valid with wr_en=0 gives retired=0x0000 and no RF change. Asserting reset mid-burst → retired=0 immediately, without waiting for a clock edge.
